// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline constants for the fetch stage: instruction encodings,
// FSM state encodings and the PC increment.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam int unsigned PC_INCR    = 4;

endpackage

// File: rtl/instruction_fetch_unit_instruction_memory.sv
// Single-port instruction memory: synchronous write, synchronous read whose
// output register doubles as the IF/ID instruction register.
module instruction_memory
  import instruction_fetch_unit_pkg::*;
#(
  parameter  int unsigned IMEM_DEPTH = 256,
  localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic               i_re,
  input  logic               i_clr,
  input  logic [IMEM_AW-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic [31:0]        o_peek_c
);

  logic [31:0] r_mem [IMEM_DEPTH];
  logic [31:0] r_rdata;

  // Storage is intentionally not reset; the debug unit loads it.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= NOP_INSTR;
    end else if (i_clr) begin
      r_rdata <= NOP_INSTR;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  // Word about to be captured, so HALT is flagged on the same edge it is delivered.
  assign o_peek_c = r_mem[i_addr];
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: PC register, redirect capture across stalls, HALT detection
// and the IF/ID output registers, sequenced by a load/run/halt FSM.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter  int unsigned NBITS      = 32,
  parameter  int unsigned IMEM_DEPTH = 256,
  localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_redirect,
  input  logic [NBITS-1:0] i_redirect_addr,
  input  logic             i_load_en,
  input  logic [NBITS-1:0] i_load_addr,
  input  logic [31:0]      i_load_data,
  output logic [NBITS-1:0] o_pc,
  output logic [31:0]      o_instruction,
  output logic             o_valid,
  output logic             o_halt,
  output logic [1:0]       o_state
);

  state_e             r_state;
  state_e             w_state_next;
  logic [NBITS-1:0]   r_pc;
  logic [NBITS-1:0]   r_pc_out;
  logic               r_valid;
  logic               r_halt;
  logic               r_pending;
  logic [NBITS-1:0]   r_pending_addr;

  logic               w_load;
  logic               w_flush;
  logic               w_fetch;
  logic               w_is_halt;
  logic               w_advance;
  logic               w_capture;
  logic               w_halt_clr;
  logic [NBITS-1:0]   w_next_pc;
  logic [NBITS-1:0]   w_redirect_aligned;
  logic [IMEM_AW-1:0] w_mem_addr;
  logic [31:0]        w_rdata;
  logic [31:0]        w_peek;
  logic               w_unused;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a load in IDLE takes precedence over starting to run.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_enable && !i_load_en) w_state_next = S_RUN;
      S_RUN:   if (w_is_halt) w_state_next = S_HALT;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-state control: flush beats stall, stall beats fetch, enable gates all.
  always_comb begin
    w_load     = 1'b0;
    w_flush    = 1'b0;
    w_fetch    = 1'b0;
    w_capture  = 1'b0;
    w_halt_clr = 1'b0;
    case (r_state)
      S_IDLE: w_load = i_load_en;
      S_RUN: begin
        w_flush   = i_enable && i_flush;
        w_fetch   = i_enable && !i_flush && !i_stall;
        w_capture = i_enable && !i_flush && i_stall && i_redirect;
      end
      S_HALT: begin
        w_load     = i_load_en;
        w_halt_clr = i_enable;
      end
      default: ;
    endcase
  end

  assign w_is_halt = w_fetch && (w_peek == HALT_INSTR);
  assign w_advance = w_flush || (w_fetch && !w_is_halt);

  // Misaligned targets are truncated to a word boundary.
  assign w_redirect_aligned = {i_redirect_addr[NBITS-1:2], 2'b00};

  always_comb begin
    if (i_redirect) begin
      w_next_pc = w_redirect_aligned;
    end else if (r_pending) begin
      w_next_pc = r_pending_addr;
    end else begin
      w_next_pc = r_pc + NBITS'(PC_INCR);
    end
  end

  assign w_mem_addr = w_load ? i_load_addr[IMEM_AW+1:2] : r_pc[IMEM_AW+1:2];

  instruction_memory #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_load),
    .i_re     (w_fetch),
    .i_clr    (w_flush || w_halt_clr),
    .i_addr   (w_mem_addr),
    .i_wdata  (i_load_data),
    .o_rdata  (w_rdata),
    .o_peek_c (w_peek)
  );

  // PC, redirect capture and IF/ID side-band registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc           <= '0;
      r_pc_out       <= '0;
      r_valid        <= 1'b0;
      r_halt         <= 1'b0;
      r_pending      <= 1'b0;
      r_pending_addr <= '0;
    end else begin
      if (w_fetch) begin
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
        if (w_is_halt) r_halt <= 1'b1;
      end else if (w_flush) begin
        r_pc_out <= r_pc;
        r_valid  <= 1'b0;
      end else if (w_halt_clr) begin
        r_valid  <= 1'b0;
      end

      if (w_advance) begin
        r_pc      <= w_next_pc;
        r_pending <= 1'b0;
      end else if (w_capture) begin
        r_pending      <= 1'b1;
        r_pending_addr <= w_redirect_aligned;
      end
    end
  end

  assign o_pc          = r_pc_out;
  assign o_instruction = w_rdata;
  assign o_valid       = r_valid;
  assign o_halt        = r_halt;
  assign o_state       = r_state;

  assign w_unused = ^{i_load_addr[NBITS-1:IMEM_AW+2], i_load_addr[1:0],
                      i_redirect_addr[1:0]};

endmodule
